// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory bus between instruction fetch
// and data memory, with registered bus request and a watchdog for hung transfers.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  output logic                    o_if_ack,
  input  logic                    i_dm_req,
  input  logic                    i_dm_we,
  input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
  input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_dm_be,
  output logic [DATA_WIDTH-1:0]   o_dm_rdata,
  output logic                    o_dm_ack,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  input  logic                    i_mem_ack,
  output logic                    o_err,
  output logic                    o_busy
);

  localparam int unsigned CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW:0] TO_LIMIT = (CW+1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last_dm;
  logic [CW-1:0] r_wdog;
  logic [CW:0]   w_wdog_inc;
  logic          w_timeout;
  logic          w_pick_dm;

  // The watchdog fires on the cycle that would make the stall count reach the limit;
  // an ack in that same cycle takes priority.
  always_comb begin
    w_wdog_inc = {1'b0, r_wdog} + (CW+1)'(1);
    w_timeout  = (TIMEOUT_CYCLES != 0) && !i_mem_ack && (w_wdog_inc == TO_LIMIT);
    w_pick_dm  = i_dm_req && (!i_if_req || !r_last_dm);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_last_dm   <= 1'b0;
      r_wdog      <= '0;
      o_if_rdata  <= '0;
      o_if_ack    <= 1'b0;
      o_dm_rdata  <= '0;
      o_dm_ack    <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= '0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_if_ack <= 1'b0;
      o_dm_ack <= 1'b0;
      o_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          if (w_pick_dm) begin
            r_state     <= GNT_DM;
            r_last_dm   <= 1'b1;
            o_mem_req   <= 1'b1;
            o_busy      <= 1'b1;
            o_mem_we    <= i_dm_we;
            o_mem_addr  <= i_dm_addr;
            o_mem_wdata <= i_dm_wdata;
            o_mem_be    <= i_dm_be;
          end else if (i_if_req) begin
            r_state     <= GNT_IF;
            r_last_dm   <= 1'b0;
            o_mem_req   <= 1'b1;
            o_busy      <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= i_if_addr;
            o_mem_wdata <= '0;
            o_mem_be    <= '1;
          end
        end
        GNT_IF, GNT_DM: begin
          if (i_mem_ack || w_timeout) begin
            r_state   <= IDLE;
            o_mem_req <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= !i_mem_ack;
            if (r_state == GNT_IF) begin
              o_if_ack   <= 1'b1;
              o_if_rdata <= i_mem_ack ? i_mem_rdata : '1;
            end else begin
              o_dm_ack <= 1'b1;
              if (!i_mem_ack)
                o_dm_rdata <= '1;
              else if (!o_mem_we)
                o_dm_rdata <= i_mem_rdata;
            end
          end else begin
            r_wdog <= w_wdog_inc[CW-1:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 4;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        mem_req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        if_ack;
    logic        dm_ack;
    logic [31:0] if_rdata;
    logic [31:0] dm_rdata;
    logic        err;
    logic        busy;
  } outs_t;

  typedef struct packed {
    in_t   i;
    outs_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_if_req = 1'b0, i_dm_req = 1'b0, i_dm_we = 1'b0, i_mem_ack = 1'b0;
  logic [31:0] i_if_addr = '0, i_dm_addr = '0, i_dm_wdata = '0, i_mem_rdata = '0;
  logic [3:0]  i_dm_be = '0;
  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        o_if_ack, o_dm_ack, o_mem_req, o_mem_we, o_err, o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .i_dm_be(i_dm_be), .o_dm_rdata(o_dm_rdata), .o_dm_ack(o_dm_ack),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_rdata(i_mem_rdata),
    .i_mem_ack(i_mem_ack), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic in_t I(logic ifr, logic [31:0] ia, logic dr, logic we, logic [31:0] da,
                            logic [31:0] wd, logic [3:0] be, logic ack, logic [31:0] rd);
    in_t x;
    x = '{ifr, ia, dr, we, da, wd, be, ack, rd};
    return x;
  endfunction

  function automatic outs_t O(logic req, logic we, logic [31:0] addr, logic [31:0] wd,
                              logic [3:0] be, logic ia, logic da, logic [31:0] ird,
                              logic [31:0] drd, logic err);
    outs_t x;
    x = '{req, we, addr, wd, be, ia, da, ird, drd, err, req};
    return x;
  endfunction

  // Bus fields only matter while a request is up, write data only for writes.
  function automatic outs_t view(outs_t o);
    outs_t v;
    v = o;
    if (!v.mem_req) begin
      v.we = 1'b0; v.addr = '0; v.wdata = '0; v.be = '0;
    end else if (!v.we) begin
      v.wdata = '0;
    end
    return v;
  endfunction

  function automatic outs_t sample_dut();
    outs_t o;
    o = '{o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_if_ack, o_dm_ack,
          o_if_rdata, o_dm_rdata, o_err, o_busy};
    return o;
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t got;
    got = sample_dut();
    n_checks++;
    if (view(got) !== view(exp) || (o_if_ack && o_dm_ack)) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, view(got), view(exp));
    end
  endtask

  task automatic apply(input in_t x);
    i_if_req = x.if_req;  i_if_addr = x.if_addr;
    i_dm_req = x.dm_req;  i_dm_we = x.dm_we; i_dm_addr = x.dm_addr;
    i_dm_wdata = x.dm_wdata; i_dm_be = x.dm_be;
    i_mem_ack = x.mem_ack; i_mem_rdata = x.mem_rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who owns the bus, how long it has stalled, who won last.
  int    owner;        // 0 none, 1 fetch, 2 data
  int    stall;
  bit    last_dm;
  outs_t m;

  task automatic model_reset();
    owner = 0; stall = 0; last_dm = 1'b0; m = '0;
  endtask

  task automatic model_complete(input logic [31:0] data, input bit timed_out);
    if (owner == 1) begin
      m.if_ack = 1'b1;
      m.if_rdata = data;
    end else begin
      m.dm_ack = 1'b1;
      if (timed_out || !m.we) m.dm_rdata = data;
    end
    m.err = timed_out;
    owner = 0;
  endtask

  task automatic model_step(input in_t x);
    m.if_ack = 1'b0; m.dm_ack = 1'b0; m.err = 1'b0;
    if (owner == 0) begin
      stall = 0;
      if (x.dm_req && !(x.if_req && last_dm)) begin
        owner = 2; last_dm = 1'b1;
        m.we = x.dm_we; m.addr = x.dm_addr; m.wdata = x.dm_wdata; m.be = x.dm_be;
      end else if (x.if_req) begin
        owner = 1; last_dm = 1'b0;
        m.we = 1'b0; m.addr = x.if_addr; m.wdata = '0; m.be = 4'hF;
      end
    end else if (x.mem_ack) begin
      model_complete(x.mem_rdata, 1'b0);
    end else begin
      stall++;
      if (stall == TO) model_complete(32'hFFFF_FFFF, 1'b1);
    end
    m.mem_req = (owner != 0);
    m.busy    = (owner != 0);
  endtask

  vec_t  vt[12];
  in_t   idle_in;
  in_t   cur;
  outs_t zero_o;

  initial begin
    idle_in = I(0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero_o  = '0;

    vt[0]  = '{I(1, 32'h100, 0, 0, 0, 0, 4'hF, 0, 0),               O(1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0)};
    vt[1]  = '{I(1, 32'h100, 0, 0, 0, 0, 4'hF, 1, 32'h13),          O(0, 0, 0, 0, 0, 1, 0, 32'h13, 0, 0)};
    vt[2]  = '{I(0, 0, 0, 0, 0, 0, 0, 0, 0),                        O(0, 0, 0, 0, 0, 0, 0, 32'h13, 0, 0)};
    vt[3]  = '{I(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0),         O(1, 0, 32'h300, 0, 4'hF, 0, 0, 32'h13, 0, 0)};
    vt[4]  = '{I(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'hAAAA0001), O(0, 0, 0, 0, 0, 0, 1, 32'h13, 32'hAAAA0001, 0)};
    vt[5]  = '{I(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0),         O(1, 0, 32'h200, 0, 4'hF, 0, 0, 32'h13, 32'hAAAA0001, 0)};
    vt[6]  = '{I(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'h55),    O(0, 0, 0, 0, 0, 1, 0, 32'h55, 32'hAAAA0001, 0)};
    vt[7]  = '{I(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'hEE),    O(1, 0, 32'h300, 0, 4'hF, 0, 0, 32'h55, 32'hAAAA0001, 0)};
    vt[8]  = '{I(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'h77),    O(0, 0, 0, 0, 0, 0, 1, 32'h55, 32'h77, 0)};
    vt[9]  = '{I(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0),         O(1, 0, 32'h200, 0, 4'hF, 0, 0, 32'h55, 32'h77, 0)};
    vt[10] = '{I(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 1, 32'h99),    O(0, 0, 0, 0, 0, 1, 0, 32'h99, 32'h77, 0)};
    vt[11] = '{I(0, 0, 0, 0, 0, 0, 0, 1, 32'h123),                  O(0, 0, 0, 0, 0, 0, 0, 32'h99, 32'h77, 0)};

    // Power-on reset
    #1 rst = 1'b0;
    #2 check("reset_state", zero_o);
    @(negedge clk) rst = 1'b1;
    step();
    check("idle_after_reset", zero_o);

    // Single fetch, then conflicts alternating DM, IF, DM, IF
    for (int k = 0; k < 12; k++) begin
      apply(vt[k].i);
      step();
      check($sformatf("vec%0d", k), vt[k].e);
    end

    // DM write with three wait states; read data register must not change
    apply(I(0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 0, 0));
    for (int k = 0; k < 4; k++) begin
      step();
      check("write_hold", O(1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 0, 0, 32'h99, 32'h77, 0));
    end
    apply(I(0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 1, 32'hCAFE));
    step();
    check("write_ack", O(0, 0, 0, 0, 0, 0, 1, 32'h99, 32'h77, 0));

    // Watchdog timeout: bus never acks
    apply(I(0, 0, 1, 0, 32'h40, 0, 4'hF, 0, 0));
    for (int k = 0; k < 4; k++) begin
      step();
      check("timeout_wait", O(1, 0, 32'h40, 0, 4'hF, 0, 0, 32'h99, 32'h77, 0));
    end
    step();
    check("timeout_fire", O(0, 0, 0, 0, 0, 0, 1, 32'h99, 32'hFFFFFFFF, 1));
    apply(idle_in);
    step();
    check("timeout_idle", O(0, 0, 0, 0, 0, 0, 0, 32'h99, 32'hFFFFFFFF, 0));

    // Ack lands in the cycle the watchdog would fire: normal completion
    apply(I(0, 0, 1, 0, 32'h44, 0, 4'hF, 0, 0));
    for (int k = 0; k < 4; k++) begin
      step();
      check("late_ack_wait", O(1, 0, 32'h44, 0, 4'hF, 0, 0, 32'h99, 32'hFFFFFFFF, 0));
    end
    apply(I(0, 0, 1, 0, 32'h44, 0, 4'hF, 1, 32'h12345678));
    step();
    check("late_ack_done", O(0, 0, 0, 0, 0, 0, 1, 32'h99, 32'h12345678, 0));
    apply(idle_in);
    step();

    // Reset mid-transfer, then the first conflict must again go to DM
    apply(I(0, 0, 1, 0, 32'h48, 0, 4'hF, 0, 0));
    step();
    check("pre_reset_req", O(1, 0, 32'h48, 0, 4'hF, 0, 0, 32'h99, 32'h12345678, 0));
    #2 rst = 1'b0;
    #1 check("async_reset", zero_o);
    apply(idle_in);
    #3 rst = 1'b1;
    step();
    step();
    check("post_reset_idle", zero_o);
    apply(I(1, 32'h500, 1, 0, 32'h600, 0, 4'hF, 0, 0));
    step();
    check("post_reset_conflict", O(1, 0, 32'h600, 0, 4'hF, 0, 0, 0, 0, 0));
    apply(I(1, 32'h500, 1, 0, 32'h600, 0, 4'hF, 1, 32'h1));
    step();
    check("post_reset_ack", O(0, 0, 0, 0, 0, 0, 1, 0, 32'h1, 0));

    // Randomized run against the reference model
    apply(idle_in);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk) rst = 1'b1;
    cur = idle_in;
    for (int c = 0; c < 3000; c++) begin
      cur.mem_ack   = ($urandom_range(2) == 0);
      cur.mem_rdata = $urandom;
      apply(cur);
      model_step(cur);
      step();
      check("random", m);
      if (m.if_ack || (!cur.if_req && $urandom_range(2) == 0)) begin
        cur.if_req  = m.if_ack ? 1'($urandom_range(1)) : 1'b1;
        cur.if_addr = $urandom;
      end
      if (m.dm_ack || (!cur.dm_req && $urandom_range(2) == 0)) begin
        cur.dm_req   = m.dm_ack ? 1'($urandom_range(1)) : 1'b1;
        cur.dm_we    = 1'($urandom_range(1));
        cur.dm_addr  = $urandom;
        cur.dm_wdata = $urandom;
        cur.dm_be    = 4'($urandom_range(15));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
